// File: rtl/signed_bin2bcd.sv
// Sequential signed-binary-to-BCD converter: latches a two's-complement product,
// converts its magnitude by double dabble one bit per clock, hands off over valid/ready.
module signed_bin2bcd #(
  parameter int W      = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_prod,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            sign;
  logic [W-1:0]    mag;
  logic [BW-1:0]   bcd;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcd_corr;
  logic [BW-1:0]   bcd_shift;
  logic [W-1:0]    mag_shift;
  logic            last_iter;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign last_iter = (cnt == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = CONVERT;
      CONVERT: if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5, then shift {bcd, mag} left by one.
  always_comb begin
    bcd_corr = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_corr[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_corr[BW-2:0], mag[W-1]};
    mag_shift = {mag[W-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign     <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      bcd_out  <= '0;
      sign_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_prod[W-1];
            mag  <= in_prod[W-1] ? (~in_prod + 1'b1) : in_prod;
            bcd  <= '0;
            cnt  <= '0;
          end
        end
        CONVERT: begin
          bcd <= bcd_shift;
          mag <= mag_shift;
          cnt <= cnt + 1'b1;
          // A zero result is never reported as negative.
          if (last_iter) begin
            bcd_out  <= bcd_shift;
            sign_out <= sign && (bcd_shift != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bin2bcd.sv
// Scoreboard bench for signed_bin2bcd: stimulus pushes reference results,
// a monitor pops and compares each result as out_valid rises.
module tb_signed_bin2bcd;

  localparam int W      = 10;
  localparam int DIGITS = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [W-1:0]    in_prod = '0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [11:0]     bcd_out;
  logic            sign_out;
  logic            busy;

  typedef struct {
    logic [11:0] bcd;
    logic        sign;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  logic prev_valid = 1'b0;

  signed_bin2bcd #(.W(W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .sign_out  (sign_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  // Reference: decimal digits of |value| by plain integer division.
  function automatic exp_t refModel(input logic [W-1:0] p, input int acc);
    exp_t e;
    int   v;
    int   m;
    v = int'($signed(p));
    m = (v < 0) ? -v : v;
    e.bcd  = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    e.sign = (v < 0);
    e.acc  = acc;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("bcd_out", int'(bcd_out), int'(e.bcd));
        checkOutput("sign_out", int'(sign_out), int'(e.sign));
        checkOutput("latency", cycle - e.acc, 10);
      end
    end
    prev_valid = out_valid;
  end

  task automatic applyStimulus(input logic [W-1:0] p);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_prod  = p;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back(refModel(p, cycle));
    in_valid = 1'b0;
    checkOutput("busy_after_accept", int'(busy), 1);
    checkOutput("in_ready_after_accept", int'(in_ready), 0);
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 0, 1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [11:0] held_bcd;
    logic        held_sign;

    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_bcd_out", int'(bcd_out), 0);
    checkOutput("reset_sign_out", int'(sign_out), 0);
    rst = 1'b0;

    applyStimulus(10'h000);
    applyStimulus(10'h0E1);
    applyStimulus(10'h310);
    applyStimulus(10'h100);
    applyStimulus(10'h200);
    waitDrain();

    // Back-pressure: result must hold while out_ready is low, new input ignored.
    out_ready = 1'b0;
    applyStimulus(10'h3C4);
    waitValid();
    held_bcd  = bcd_out;
    held_sign = sign_out;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_prod  = 10'h07B;
      @(negedge clk);
      checkOutput("stall_out_valid", int'(out_valid), 1);
      checkOutput("stall_in_ready", int'(in_ready), 0);
      checkOutput("stall_bcd_hold", int'(bcd_out), int'(held_bcd));
      checkOutput("stall_sign_hold", int'(sign_out), int'(held_sign));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", int'(in_ready), 1);
    checkOutput("release_out_valid", int'(out_valid), 0);
    checkOutput("release_busy", int'(busy), 0);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(W'($urandom_range(0, 1023)));
    end
    waitDrain();

    // Abort mid-conversion: reset must clear everything asynchronously.
    applyStimulus(10'h0E1);
    waitDrain();
    applyStimulus(10'h3FF);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_bcd_out", int'(bcd_out), 0);
    checkOutput("abort_sign_out", int'(sign_out), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_in_ready", int'(in_ready), 1);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(10'h3FF);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
